// File: rtl/cache_miss_arbiter.sv
// Arbitrates I-cache and D-cache misses onto one fill FSM / memory port.
// Latches the winning address, steers fill data, and forces a turnaround gap after each fill.
//
// state  | meaning
// IDLE   | no fill in flight; grant a pending miss at the next edge
// FILL_I | I-cache fill in progress, waiting for fill_done
// FILL_D | D-cache fill in progress, waiting for fill_done
// GAP    | turnaround so the fill FSM word counter drains; no grants
module cache_miss_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int D_PRIORITY = 1,
  parameter int FAIR       = 1,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  input  logic              fill_done,
  output logic              fill_miss_detected,
  output logic [ADDR_W-1:0] fill_miss_address,
  output logic              icache_fill_sel,
  output logic              dcache_fill_sel,
  output logic              icache_stall,
  output logic              dcache_stall
);

  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, GAP} state_t;

  localparam logic [1:0] GAP_LOAD = 2'(TURNAROUND - 1);

  state_t     state;
  logic [1:0] gap_cnt;
  logic       last_served;
  logic       have_served;
  logic       pick_d;

  // Fairness only applies once something has been served; the first grant uses D_PRIORITY.
  always_comb begin
    pick_d = dcache_miss;
    if (icache_miss && dcache_miss) begin
      if ((FAIR != 0) && have_served)
        pick_d = ~last_served;
      else
        pick_d = (D_PRIORITY != 0);
    end
  end

  // Note: rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state              <= IDLE;
      gap_cnt            <= 2'd0;
      last_served        <= 1'b0;
      have_served        <= 1'b0;
      fill_miss_detected <= 1'b0;
      fill_miss_address  <= '0;
      icache_fill_sel    <= 1'b0;
      dcache_fill_sel    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (icache_miss || dcache_miss) begin
            state              <= pick_d ? FILL_D : FILL_I;
            fill_miss_detected <= 1'b1;
            fill_miss_address  <= pick_d ? dcache_miss_addr : icache_miss_addr;
            icache_fill_sel    <= ~pick_d;
            dcache_fill_sel    <= pick_d;
          end
        end
        FILL_I, FILL_D: begin
          // Miss level and address are ignored mid-fill so the tag write is never torn.
          if (fill_done) begin
            last_served        <= (state == FILL_D);
            have_served        <= 1'b1;
            fill_miss_detected <= 1'b0;
            fill_miss_address  <= '0;
            icache_fill_sel    <= 1'b0;
            dcache_fill_sel    <= 1'b0;
            if (TURNAROUND > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 2'd0)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign icache_stall = icache_miss & ~((state == FILL_I) & fill_done);
  assign dcache_stall = dcache_miss & ~((state == FILL_D) & fill_done);

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Directed bench for cache_miss_arbiter: a vector table for reset/basic/priority
// cases, then hand-written sequences for fairness, flush and mid-fill reset.
module tb_cache_miss_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_miss;
  logic [15:0] icache_miss_addr;
  logic        dcache_miss;
  logic [15:0] dcache_miss_addr;
  logic        fill_done;
  logic        fill_miss_detected;
  logic [15:0] fill_miss_address;
  logic        icache_fill_sel;
  logic        dcache_fill_sel;
  logic        icache_stall;
  logic        dcache_stall;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cache_miss_arbiter dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .icache_miss        (icache_miss),
    .icache_miss_addr   (icache_miss_addr),
    .dcache_miss        (dcache_miss),
    .dcache_miss_addr   (dcache_miss_addr),
    .fill_done          (fill_done),
    .fill_miss_detected (fill_miss_detected),
    .fill_miss_address  (fill_miss_address),
    .icache_fill_sel    (icache_fill_sel),
    .dcache_fill_sel    (dcache_fill_sel),
    .icache_stall       (icache_stall),
    .dcache_stall       (dcache_stall)
  );

  typedef struct {
    logic        rst;
    logic        im;
    logic [15:0] ia;
    logic        dm;
    logic [15:0] da;
    logic        fd;
    logic        det;
    logic [15:0] addr;
    logic        isel;
    logic        dsel;
    logic        istall;
    logic        dstall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic add(input logic rst, input logic im, input logic [15:0] ia,
                     input logic dm, input logic [15:0] da, input logic fd,
                     input logic det, input logic [15:0] addr, input logic isel,
                     input logic dsel, input logic istall, input logic dstall);
    vec_t v;
    v.rst = rst; v.im = im; v.ia = ia; v.dm = dm; v.da = da; v.fd = fd;
    v.det = det; v.addr = addr; v.isel = isel; v.dsel = dsel;
    v.istall = istall; v.dstall = dstall;
    vecs.push_back(v);
  endtask

  // Drive after the rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic rst, input logic im, input logic [15:0] ia,
                       input logic dm, input logic [15:0] da, input logic fd);
    @(posedge clk); #1;
    rst_n = rst; icache_miss = im; icache_miss_addr = ia;
    dcache_miss = dm; dcache_miss_addr = da; fill_done = fd;
    @(negedge clk);
  endtask

  task automatic wait_det(input string name, input logic im, input logic [15:0] ia,
                          input logic dm, input logic [15:0] da);
    int n = 0;
    drive(1'b0, im, ia, dm, da, 1'b0);
    while (!fill_miss_detected && n < 8) begin
      drive(1'b0, im, ia, dm, da, 1'b0);
      n++;
    end
    check({name, "_grant_timeout"}, 32'(fill_miss_detected), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1; icache_miss = 1'b0; icache_miss_addr = '0;
    dcache_miss = 1'b0; dcache_miss_addr = '0; fill_done = 1'b0;

    //   rst im ia       dm da       fd | det addr     is ds ist dst
    add(1, 1, 16'h1000, 1, 16'h2000, 0,  0, 16'h0000, 0, 0, 1, 1);
    add(1, 1, 16'h1000, 1, 16'h2000, 0,  0, 16'h0000, 0, 0, 1, 1);
    add(0, 1, 16'h1234, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 1, 0);
    add(0, 1, 16'h1234, 0, 16'h0000, 0,  1, 16'h1234, 1, 0, 1, 0);
    add(0, 1, 16'h1234, 0, 16'h0000, 1,  1, 16'h1234, 1, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 0);
    add(1, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 16'h1000, 1, 16'h2000, 0,  0, 16'h0000, 0, 0, 1, 1);
    add(0, 1, 16'h1000, 1, 16'h2000, 0,  1, 16'h2000, 0, 1, 1, 1);
    add(0, 1, 16'h1000, 1, 16'h2000, 1,  1, 16'h2000, 0, 1, 1, 0);
    add(0, 1, 16'h1000, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 1, 0);
    add(0, 1, 16'h1000, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 1, 0);
    add(0, 1, 16'h1000, 0, 16'h0000, 0,  1, 16'h1000, 1, 0, 1, 0);
    add(0, 1, 16'h1000, 0, 16'h0000, 1,  1, 16'h1000, 1, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].im, vecs[i].ia, vecs[i].dm, vecs[i].da, vecs[i].fd);
      check($sformatf("v%0d_det", i),    32'(fill_miss_detected), 32'(vecs[i].det));
      check($sformatf("v%0d_addr", i),   32'(fill_miss_address),  32'(vecs[i].addr));
      check($sformatf("v%0d_isel", i),   32'(icache_fill_sel),    32'(vecs[i].isel));
      check($sformatf("v%0d_dsel", i),   32'(dcache_fill_sel),    32'(vecs[i].dsel));
      check($sformatf("v%0d_istall", i), 32'(icache_stall),       32'(vecs[i].istall));
      check($sformatf("v%0d_dstall", i), 32'(dcache_stall),       32'(vecs[i].dstall));
    end

    // Fairness: last served was I, so both-pending grants go D, I, D, I.
    for (int k = 0; k < 4; k++) begin
      logic        exp_d;
      logic [15:0] ia, da;
      exp_d = (k % 2 == 0);
      ia = 16'h3000 + 16'(k);
      da = 16'h4000 + 16'(k);
      wait_det($sformatf("fair%0d", k), 1'b1, ia, 1'b1, da);
      check($sformatf("fair%0d_dsel", k), 32'(dcache_fill_sel), 32'(exp_d));
      check($sformatf("fair%0d_isel", k), 32'(icache_fill_sel), 32'(!exp_d));
      check($sformatf("fair%0d_addr", k), 32'(fill_miss_address), 32'(exp_d ? da : ia));
      drive(1'b0, 1'b1, 16'hBEEE, 1'b1, 16'hBEEF, 1'b0);
      check($sformatf("fair%0d_addr_hold", k), 32'(fill_miss_address), 32'(exp_d ? da : ia));
      drive(1'b0, 1'b1, 16'hBEEE, 1'b1, 16'hBEEF, 1'b1);
      check($sformatf("fair%0d_istall", k), 32'(icache_stall), 32'(exp_d));
      check($sformatf("fair%0d_dstall", k), 32'(dcache_stall), 32'(!exp_d));
    end

    // Flush: D drops its miss mid-fill; the fill must still run to fill_done.
    wait_det("flush", 1'b0, 16'h0000, 1'b1, 16'h5000);
    check("flush_dsel", 32'(dcache_fill_sel), 32'd1);
    check("flush_addr", 32'(fill_miss_address), 32'h5000);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    check("flush_det_held1", 32'(fill_miss_detected), 32'd1);
    check("flush_dstall", 32'(dcache_stall), 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    check("flush_det_held2", 32'(fill_miss_detected), 32'd1);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    check("flush_det_done", 32'(fill_miss_detected), 32'd1);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    check("flush_det_drop", 32'(fill_miss_detected), 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Reset mid FILL_I: outputs clear asynchronously, re-grant one cycle after release.
    wait_det("rstfill", 1'b1, 16'h6000, 1'b0, 16'h0000);
    check("rstfill_isel", 32'(icache_fill_sel), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rstfill_det_async",  32'(fill_miss_detected), 32'd0);
    check("rstfill_isel_async", 32'(icache_fill_sel), 32'd0);
    check("rstfill_addr_async", 32'(fill_miss_address), 32'h0000);
    check("rstfill_istall",     32'(icache_stall), 32'd1);
    drive(1'b1, 1'b1, 16'h6000, 1'b0, 16'h0000, 1'b0);
    check("rstfill_det_held", 32'(fill_miss_detected), 32'd0);
    drive(1'b0, 1'b1, 16'h6000, 1'b0, 16'h0000, 1'b0);
    check("rstfill_det_idle", 32'(fill_miss_detected), 32'd0);
    drive(1'b0, 1'b1, 16'h6000, 1'b0, 16'h0000, 1'b0);
    check("rstfill_regrant", 32'(fill_miss_detected), 32'd1);
    check("rstfill_readdr",  32'(fill_miss_address), 32'h6000);
    check("rstfill_resel",   32'(icache_fill_sel), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
